// File: rtl/header.vh
// Shared configuration for the issue controller: register-address width.
`ifndef AWIDTH
`define AWIDTH 5
`endif

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue (slot A older, slot B younger) issue controller.
// Detects load-use hazards against both EX pipes and intra-pair RAW/WAW hazards.
// On a pair hazard it splits the pair over two cycles. On a branch mispredict it
// flushes for FLUSH_CYCLES cycles.
// All outputs are combinational from the current state and inputs, and are
// forced to 0 while rst is high.
// Optional feature: define ISSUE_CTRL_STALL_CNT_EN to add ic_o_stall_cnt. This is
// a saturating count of cycles with hold=1 or state FLUSH.
//
// Handshake: there is no valid/ready pair. a_i_valid/b_i_valid mark occupied
// decode slots. ic_o_issue_* means the slot leaves decode at the next edge.
// ic_o_hold means decode keeps its contents for that edge.
`include "header.vh"

module issue_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_i_valid,
    input  logic              b_i_valid,
    input  logic [`AWIDTH-1:0] a_i_rs1,
    input  logic [`AWIDTH-1:0] a_i_rs2,
    input  logic [`AWIDTH-1:0] a_i_rd,
    input  logic [`AWIDTH-1:0] b_i_rs1,
    input  logic [`AWIDTH-1:0] b_i_rs2,
    input  logic [`AWIDTH-1:0] b_i_rd,
    input  logic              a_i_regwrite,
    input  logic              a_i_memread,
    input  logic              b_i_regwrite,
    input  logic              b_i_memread,
    input  logic [`AWIDTH-1:0] ex_a_i_rd,
    input  logic [`AWIDTH-1:0] ex_b_i_rd,
    input  logic              ex_a_i_regwrite,
    input  logic              ex_a_i_memread,
    input  logic              ex_b_i_regwrite,
    input  logic              ex_b_i_memread,
    input  logic              br_i_mispredict,
    output logic              ic_o_issue_a,
    output logic              ic_o_issue_b,
    output logic              ic_o_hold,
    output logic              ic_o_bubble,
    output logic              ic_o_flush,
    output logic [1:0]        ic_o_state
`ifdef ISSUE_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]       ic_o_stall_cnt
`endif
);

    localparam int AW = `AWIDTH;
    localparam logic [3:0] LP_FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SPLIT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_flush_cnt;
    logic [3:0] w_flush_cnt_nxt;

    logic w_ex_a_load;
    logic w_ex_b_load;
    logic w_a_lu;
    logic w_b_lu;
    logic w_pair;

    logic       w_issue_a;
    logic       w_issue_b;
    logic       w_hold;
    logic       w_bubble;
    logic       w_flush;
    logic [1:0] w_state_out;

    // Hazard detection: register 0 is never live; invalid slots never hazard.
    always_comb begin
        w_ex_a_load = ex_a_i_memread & ex_a_i_regwrite;
        w_ex_b_load = ex_b_i_memread & ex_b_i_regwrite;

        w_a_lu = a_i_valid & (
                   ((a_i_rs1 != AW'(0)) &
                    ((w_ex_a_load & (a_i_rs1 == ex_a_i_rd)) |
                     (w_ex_b_load & (a_i_rs1 == ex_b_i_rd)))) |
                   ((a_i_rs2 != AW'(0)) &
                    ((w_ex_a_load & (a_i_rs2 == ex_a_i_rd)) |
                     (w_ex_b_load & (a_i_rs2 == ex_b_i_rd)))));

        w_b_lu = b_i_valid & (
                   ((b_i_rs1 != AW'(0)) &
                    ((w_ex_a_load & (b_i_rs1 == ex_a_i_rd)) |
                     (w_ex_b_load & (b_i_rs1 == ex_b_i_rd)))) |
                   ((b_i_rs2 != AW'(0)) &
                    ((w_ex_a_load & (b_i_rs2 == ex_a_i_rd)) |
                     (w_ex_b_load & (b_i_rs2 == ex_b_i_rd)))));

        w_pair = a_i_valid & b_i_valid & a_i_regwrite & (a_i_rd != AW'(0)) &
                 ((a_i_rd == b_i_rs1) | (a_i_rd == b_i_rs2) |
                  (b_i_regwrite & (a_i_rd == b_i_rd)));
    end

    // State and flush-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Next-state and output decode; mispredict overrides every legal state.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_issue_a       = 1'b0;
        w_issue_b       = 1'b0;
        w_hold          = 1'b0;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        w_state_out     = r_state;

        if (rst) begin
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = 4'd0;
            w_state_out     = 2'd0;
        end else if (r_state == ST_BAD) begin
            // Illegal encoding: recover quietly to RUN.
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = 4'd0;
            w_state_out     = 2'd0;
        end else if (br_i_mispredict) begin
            w_flush         = 1'b1;
            w_bubble        = 1'b1;
            w_flush_cnt_nxt = LP_FLUSH_LOAD;
            w_state_nxt     = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_a_lu | w_b_lu) begin
                        w_hold   = 1'b1;
                        w_bubble = 1'b1;
                    end else if (w_pair) begin
                        w_issue_a   = 1'b1;
                        w_hold      = 1'b1;
                        w_state_nxt = ST_SPLIT;
                    end else begin
                        w_issue_a = a_i_valid;
                        w_issue_b = b_i_valid;
                    end
                end
                ST_SPLIT: begin
                    // Slot A already left; only the held younger slot matters.
                    if (w_b_lu) begin
                        w_hold   = 1'b1;
                        w_bubble = 1'b1;
                    end else begin
                        w_issue_b   = 1'b1;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (r_flush_cnt <= 4'd1) begin
                        w_flush_cnt_nxt = 4'd0;
                        w_state_nxt     = ST_RUN;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign ic_o_issue_a = w_issue_a;
    assign ic_o_issue_b = w_issue_b;
    assign ic_o_hold    = w_hold;
    assign ic_o_bubble  = w_bubble;
    assign ic_o_flush   = w_flush;
    assign ic_o_state   = w_state_out;

`ifdef ISSUE_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of stalled cycles (held decode or flushing).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if ((w_hold | (r_state == ST_FLUSH)) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign ic_o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios plus randomized traffic.
// The expected outputs come from a behavioural reference model in this file.
`ifndef AWIDTH
`define AWIDTH 5
`endif

module tb_issue_ctrl;
  localparam int AW = `AWIDTH;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  logic a_i_valid, b_i_valid;
  logic [AW-1:0] a_i_rs1, a_i_rs2, a_i_rd, b_i_rs1, b_i_rs2, b_i_rd;
  logic a_i_regwrite, a_i_memread, b_i_regwrite, b_i_memread;
  logic [AW-1:0] ex_a_i_rd, ex_b_i_rd;
  logic ex_a_i_regwrite, ex_a_i_memread, ex_b_i_regwrite, ex_b_i_memread;
  logic br_i_mispredict;
  logic ic_o_issue_a, ic_o_issue_b, ic_o_hold, ic_o_bubble, ic_o_flush;
  logic [1:0] ic_o_state;
`ifdef ISSUE_CTRL_STALL_CNT_EN
  logic [31:0] ic_o_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: mode 0 run, 1 split, 2 flush; flush cycles left
  int m_mode = 0;
  int m_left = 0;
  int m_next_mode;
  int m_next_left;
  longint m_stall = 0;
  int flush_seen = 0;
  logic [6:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  issue_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .a_i_valid(a_i_valid), .b_i_valid(b_i_valid),
    .a_i_rs1(a_i_rs1), .a_i_rs2(a_i_rs2), .a_i_rd(a_i_rd),
    .b_i_rs1(b_i_rs1), .b_i_rs2(b_i_rs2), .b_i_rd(b_i_rd),
    .a_i_regwrite(a_i_regwrite), .a_i_memread(a_i_memread),
    .b_i_regwrite(b_i_regwrite), .b_i_memread(b_i_memread),
    .ex_a_i_rd(ex_a_i_rd), .ex_b_i_rd(ex_b_i_rd),
    .ex_a_i_regwrite(ex_a_i_regwrite), .ex_a_i_memread(ex_a_i_memread),
    .ex_b_i_regwrite(ex_b_i_regwrite), .ex_b_i_memread(ex_b_i_memread),
    .br_i_mispredict(br_i_mispredict),
    .ic_o_issue_a(ic_o_issue_a), .ic_o_issue_b(ic_o_issue_b),
    .ic_o_hold(ic_o_hold), .ic_o_bubble(ic_o_bubble),
    .ic_o_flush(ic_o_flush), .ic_o_state(ic_o_state)
`ifdef ISSUE_CTRL_STALL_CNT_EN
    , .ic_o_stall_cnt(ic_o_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // true if register r (nonzero) is the destination of a load now in EX
  function automatic bit reads_load(input int r);
    int loads[$];
    if (ex_a_i_memread && ex_a_i_regwrite) loads.push_back(int'(ex_a_i_rd));
    if (ex_b_i_memread && ex_b_i_regwrite) loads.push_back(int'(ex_b_i_rd));
    if (r == 0) return 0;
    foreach (loads[k]) if (loads[k] == r) return 1;
    return 0;
  endfunction

  function automatic bit slot_lu(input logic v, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    return v && (reads_load(int'(s1)) || reads_load(int'(s2)));
  endfunction

  // expected {issue_a, issue_b, hold, bubble, flush, state[1:0]} and next mode
  task automatic model_eval(output logic [6:0] e);
    bit ia, ib, hd, bb, fl;
    bit pair;
    ia = 0; ib = 0; hd = 0; bb = 0; fl = 0;
    m_next_mode = m_mode;
    m_next_left = m_left;
    pair = a_i_valid && b_i_valid && a_i_regwrite && (a_i_rd != 0) &&
           (a_i_rd == b_i_rs1 || a_i_rd == b_i_rs2 || (b_i_regwrite && a_i_rd == b_i_rd));
    if (rst) begin
      m_next_mode = 0;
      m_next_left = 0;
      e = 7'd0;
      return;
    end
    if (br_i_mispredict) begin
      fl = 1; bb = 1;
      m_next_mode = 2;
      m_next_left = FC;
    end else if (m_mode == 0) begin
      if (slot_lu(a_i_valid, a_i_rs1, a_i_rs2) || slot_lu(b_i_valid, b_i_rs1, b_i_rs2)) begin
        hd = 1; bb = 1;
      end else if (pair) begin
        ia = 1; hd = 1;
        m_next_mode = 1;
      end else begin
        ia = a_i_valid; ib = b_i_valid;
      end
    end else if (m_mode == 1) begin
      if (slot_lu(b_i_valid, b_i_rs1, b_i_rs2)) begin
        hd = 1; bb = 1;
      end else begin
        ib = 1;
        m_next_mode = 0;
      end
    end else begin
      fl = 1; bb = 1;
      m_next_left = m_left - 1;
      if (m_next_left == 0) m_next_mode = 0;
    end
    e = {ia, ib, hd, bb, fl, 2'(m_mode)};
  endtask

  // one clock: compare at negedge, advance model at posedge
  task automatic run_cycle();
    logic [6:0] e;
    logic [6:0] x;
    @(negedge clk);
    model_eval(e);
    exp_q.push_back(e);
    x = exp_q.pop_front();
    check("issue_a", 32'(ic_o_issue_a), 32'(x[6]));
    check("issue_b", 32'(ic_o_issue_b), 32'(x[5]));
    check("hold",    32'(ic_o_hold),    32'(x[4]));
    check("bubble",  32'(ic_o_bubble),  32'(x[3]));
    check("flush",   32'(ic_o_flush),   32'(x[2]));
    check("state",   32'(ic_o_state),   32'(x[1:0]));
`ifdef ISSUE_CTRL_STALL_CNT_EN
    check("stall_cnt", ic_o_stall_cnt, 32'(m_stall));
`endif
    if (ic_o_flush) flush_seen++;
    @(posedge clk);
    if (rst) m_stall = 0;
    else if ((x[4] || m_mode == 2) && m_stall != 64'hFFFF_FFFF) m_stall++;
    m_mode = m_next_mode;
    m_left = m_next_left;
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0;
    a_i_valid = 0; b_i_valid = 0;
    a_i_rs1 = '0; a_i_rs2 = '0; a_i_rd = '0;
    b_i_rs1 = '0; b_i_rs2 = '0; b_i_rd = '0;
    a_i_regwrite = 0; a_i_memread = 0; b_i_regwrite = 0; b_i_memread = 0;
    ex_a_i_rd = '0; ex_b_i_rd = '0;
    ex_a_i_regwrite = 0; ex_a_i_memread = 0; ex_b_i_regwrite = 0; ex_b_i_memread = 0;
    br_i_mispredict = 0;
  endtask

  // slot A writes rd_a; slot B reads bs1/bs2 and writes rd 6
  task automatic set_pair(input int rd_a, input bit a_load, input int bs1, input int bs2);
    a_i_valid = 1; a_i_regwrite = 1; a_i_memread = a_load;
    a_i_rd = AW'(rd_a); a_i_rs1 = AW'(1); a_i_rs2 = AW'(0);
    b_i_valid = 1; b_i_regwrite = 1; b_i_memread = 0;
    b_i_rs1 = AW'(bs1); b_i_rs2 = AW'(bs2); b_i_rd = AW'(6);
  endtask

  task automatic drive_random();
    rst = ($urandom_range(0, 99) == 0);
    br_i_mispredict = ($urandom_range(0, 19) == 0);
    a_i_valid = ($urandom_range(0, 3) != 0);
    b_i_valid = ($urandom_range(0, 3) != 0);
    a_i_rs1 = AW'($urandom_range(0, 7)); a_i_rs2 = AW'($urandom_range(0, 7));
    a_i_rd  = AW'($urandom_range(0, 7));
    b_i_rs1 = AW'($urandom_range(0, 7)); b_i_rs2 = AW'($urandom_range(0, 7));
    b_i_rd  = AW'($urandom_range(0, 7));
    a_i_regwrite = 1'($urandom); a_i_memread = 1'($urandom);
    b_i_regwrite = 1'($urandom); b_i_memread = 1'($urandom);
    ex_a_i_rd = AW'($urandom_range(0, 7)); ex_b_i_rd = AW'($urandom_range(0, 7));
    ex_a_i_regwrite = 1'($urandom); ex_a_i_memread = ($urandom_range(0, 2) == 0);
    ex_b_i_regwrite = 1'($urandom); ex_b_i_memread = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    a_i_valid = 1; b_i_valid = 1; br_i_mispredict = 1;
    run_cycle();
    run_cycle();
    clear_inputs();

    // independent pair issues together
    a_i_valid = 1; a_i_regwrite = 1; a_i_rd = AW'(3); a_i_rs1 = AW'(1); a_i_rs2 = AW'(2);
    b_i_valid = 1; b_i_regwrite = 1; b_i_rd = AW'(6); b_i_rs1 = AW'(5);
    run_cycle();

    // RAW inside the pair splits it
    set_pair(4, 0, 4, 0);
    run_cycle();
    run_cycle();

    // load in EX A feeding slot A, then EX drains
    clear_inputs();
    a_i_valid = 1; a_i_rs1 = AW'(7); a_i_rd = AW'(3); a_i_regwrite = 1;
    b_i_valid = 1; b_i_rs1 = AW'(5);
    ex_a_i_rd = AW'(7); ex_a_i_memread = 1; ex_a_i_regwrite = 1;
    run_cycle();
    ex_a_i_memread = 0; ex_a_i_regwrite = 0; ex_a_i_rd = '0;
    run_cycle();

    // load in the pair, then load-use on B while split
    clear_inputs();
    set_pair(2, 1, 2, 0);
    run_cycle();
    ex_a_i_rd = AW'(2); ex_a_i_memread = 1; ex_a_i_regwrite = 1;
    run_cycle();
    ex_a_i_memread = 0; ex_a_i_regwrite = 0;
    run_cycle();

    // mispredict inside SPLIT: flush lasts entry + FC cycles
    clear_inputs();
    set_pair(4, 0, 4, 0);
    run_cycle();
    flush_seen = 0;
    br_i_mispredict = 1;
    run_cycle();
    br_i_mispredict = 0;
    for (int i = 0; i < FC + 1; i++) run_cycle();
    check("flush_len", 32'(flush_seen), 32'(FC + 1));

    // second mispredict during FLUSH reloads the count
    flush_seen = 0;
    br_i_mispredict = 1;
    run_cycle();
    br_i_mispredict = 0;
    run_cycle();
    br_i_mispredict = 1;
    run_cycle();
    br_i_mispredict = 0;
    for (int i = 0; i < FC + 1; i++) run_cycle();
    check("flush_reload_len", 32'(flush_seen), 32'(FC + 3));

    // reset in the middle of FLUSH
    br_i_mispredict = 1;
    run_cycle();
    br_i_mispredict = 0;
    rst = 1;
    run_cycle();
    rst = 0;
    run_cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles the FLUSH state lasts after a mispredict (legal 1..15).
REQ-002 Register-address width SHALL be `AWIDTH from header.vh; written as AW below.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_i_valid, b_i_valid  input  1 each  decode slot A (older) / B (younger) holds an instruction.
REQ-006 a_i_rs1, a_i_rs2, a_i_rd, b_i_rs1, b_i_rs2, b_i_rd  input  AW each  source/destination register addresses per slot.
REQ-007 a_i_regwrite, a_i_memread, b_i_regwrite, b_i_memread  input  1 each  slot writes a register / slot is a load.
REQ-008 ex_a_i_rd, ex_b_i_rd  input  AW each  destination of the instruction currently in pipe A / pipe B EX.
REQ-009 ex_a_i_regwrite, ex_a_i_memread, ex_b_i_regwrite, ex_b_i_memread  input  1 each  EX-stage write and load flags per pipe.
REQ-010 br_i_mispredict  input  1  branch resolved as mispredicted this cycle.
REQ-011 ic_o_issue_a, ic_o_issue_b  output  1 each  slot A / slot B enters its pipe's EX next edge.
REQ-012 ic_o_hold  output  1  decode register holds its contents.
REQ-013 ic_o_bubble  output  1  NOP injected into both EX stages.
REQ-014 ic_o_flush  output  1  fetch/decode contents discarded.
REQ-015 ic_o_state  output  2  current state: 0 RUN, 1 SPLIT, 2 FLUSH.

Function
REQ-016 Register r is live only if nonzero; an invalid slot never causes any hazard.
REQ-017 Load-use hazard for slot X: a nonzero rs1/rs2 of X equals ex_a_i_rd with ex_a_i_memread&&ex_a_i_regwrite, or equals ex_b_i_rd with ex_b_i_memread&&ex_b_i_regwrite.
REQ-018 Pair hazard: both slots valid, a_i_regwrite, a_i_rd nonzero, and a_i_rd equals b_i_rs1, b_i_rs2, or (b_i_regwrite) b_i_rd.
REQ-019 All outputs SHALL be combinational from state and current inputs (zero-cycle latency); state and counter update on the edge.
REQ-020 RUN, load-use hazard on any valid slot: hold=1, bubble=1, issue_a=issue_b=0, stay RUN.
REQ-021 RUN, no load-use, pair hazard: issue_a=1, issue_b=0, hold=1, next SPLIT.
REQ-022 RUN, no hazard: issue_a=a_i_valid, issue_b=b_i_valid, hold=0, stay RUN.
REQ-023 SPLIT: slot B only is evaluated; load-use on B gives hold=1, bubble=1, stay SPLIT; otherwise issue_b=1, hold=0, next RUN.
REQ-024 br_i_mispredict SHALL take priority in every state: flush=1, bubble=1, hold=0, issue_a=issue_b=0, counter loaded with FLUSH_CYCLES, next FLUSH.
REQ-025 FLUSH: flush=1, bubble=1, no issue, hold=0; counter decrements each cycle; on counter==1 next RUN.
REQ-026 Mispredict while in FLUSH SHALL reload the counter to FLUSH_CYCLES.
REQ-027 Unused state encoding 3 SHALL return to RUN next edge with all outputs 0.

Reset
REQ-028 With rst high at an edge: state RUN, flush counter 0, stall counter 0.
REQ-029 While rst is high all outputs SHALL be 0, regardless of other inputs; reset mid-FLUSH or mid-SPLIT abandons that state.

Configuration
REQ-030 Macro ISSUE_CTRL_STALL_CNT_EN defined: extra output ic_o_stall_cnt (output, 32) counts cycles with hold=1 or state FLUSH, saturating at 32'hFFFFFFFF, cleared by rst.
REQ-031 Macro undefined: port, counter, and its logic absent; all other behaviour identical.

Verification
REQ-032 A: add r3; B: sub reads r5; EX empty -> issue_a=1, issue_b=1, hold=0, state stays 0.
REQ-033 A: add r4; B reads r4 -> cycle 1 issue_a=1, hold=1, state 1; cycle 2 issue_b=1, hold=0, state 0.
REQ-034 ex_a load to r7; slot A reads r7 -> hold=1, bubble=1, no issue; next cycle EX cleared -> both issue.
REQ-035 A: load r2; B reads r2 -> SPLIT; next cycle ex_a shows load r2 -> hold=1, bubble=1 in SPLIT; following cycle issue_b=1.
REQ-036 br_i_mispredict pulse in SPLIT, FLUSH_CYCLES=2 -> flush=1 for 3 cycles (entry + 2), then RUN; second pulse during FLUSH extends by reload.
REQ-037 rst asserted in FLUSH -> next edge all outputs 0, state 0; with ISSUE_CTRL_STALL_CNT_EN, ic_o_stall_cnt=0.
